and_or_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one and_or gate cell, y=(a&b)|(c&d),

---
 rtl/and_or_pkg.sv | 21 ++
 rtl/and_or.sv | 12 +
 rtl/and_or_rr_pick.sv | 33 +++
 rtl/and_or_arbiter.sv | 152 +++++++++++++++
 tb/tb_and_or_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/and_or_pkg.sv
// Shared types and constants for the and_or round-robin arbiter.
// The golden constant is the truth table of y=(a&b)|(c&d), indexed by {a,b,c,d}.
package and_or_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        RESP  = 2'd2,
        SWEEP = 2'd3
    } state_t;

    localparam logic [15:0] ANDOR_GOLDEN = 16'hF888;

    // Operand bit positions: {a,b,c,d}, a is the MSB.
    localparam int OP_W = 4;
    localparam int OP_A = 3;
    localparam int OP_B = 2;
    localparam int OP_C = 1;
    localparam int OP_D = 0;

endpackage

// File: rtl/and_or.sv
// Shared gate cell: y = (a & b) | (c & d).
module and_or (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = (a & b) | (c & d);

endmodule

// File: rtl/and_or_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr, wrapping at N_REQ.
module and_or_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        w_idx   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        // Walk the offsets downward so the smallest offset from ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (req[w_idx]) begin
                any     = 1'b1;
                gnt_idx = w_idx;
            end
        end
        gnt = any ? (N_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/and_or_arbiter.sv
// Round-robin arbiter sharing one and_or cell among N_REQ requesters.
// Optional power-on self-test of the cell: define ANDOR_ARB_SWEEP_EN.
module and_or_arbiter
    import and_or_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [OP_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_y,
    output logic                  busy
`ifdef ANDOR_ARB_SWEEP_EN
    ,
    output logic                  selftest_done,
    output logic                  selftest_fail
`endif
);

`ifdef ANDOR_ARB_SWEEP_EN
    localparam state_t RESET_STATE = SWEEP;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [OP_W-1:0] r_op;
    logic [ID_W-1:0] r_id;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_y;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_idx;
    logic             w_any;
    logic [OP_W-1:0]  w_req_op;
    logic             w_y;

    and_or_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // The single shared cell always evaluates the operand register.
    and_or u_cell (
        .a (r_op[OP_A]),
        .b (r_op[OP_B]),
        .c (r_op[OP_C]),
        .d (r_op[OP_D]),
        .y (w_y)
    );

    assign w_req_op  = req_data[{w_gnt_idx, 2'b00} +: OP_W];
    assign req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign busy      = (r_state != IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;

`ifdef ANDOR_ARB_SWEEP_EN
    logic [4:0]      r_sweep_cnt;
    logic            r_chk_vld;
    logic            r_chk_y;
    logic [OP_W-1:0] r_chk_op;
    logic            r_mis;
    logic            r_selftest_done;
    logic            r_selftest_fail;
    logic            w_mismatch;

    // Compare the cell output captured last cycle against the golden truth table.
    assign w_mismatch    = r_chk_vld && (r_chk_y != ANDOR_GOLDEN[r_chk_op]);
    assign selftest_done = r_selftest_done;
    assign selftest_fail = r_selftest_fail;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESET_STATE;
            r_ptr       <= '0;
            r_op        <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= 1'b0;
`ifdef ANDOR_ARB_SWEEP_EN
            r_sweep_cnt     <= '0;
            r_chk_vld       <= 1'b0;
            r_chk_y         <= 1'b0;
            r_chk_op        <= '0;
            r_mis           <= 1'b0;
            r_selftest_done <= 1'b0;
            r_selftest_fail <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_op    <= w_req_op;
                        r_id    <= w_gnt_idx;
                        r_ptr   <= (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_rsp_y     <= w_y;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
`ifdef ANDOR_ARB_SWEEP_EN
                SWEEP: begin
                    // Cycles 0..15 drive op=0..15; cycles 1..16 check the previous one.
                    r_chk_vld   <= (r_sweep_cnt < 5'd16);
                    r_chk_y     <= w_y;
                    r_chk_op    <= r_op;
                    r_mis       <= r_mis | w_mismatch;
                    r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    if (r_sweep_cnt < 5'd15) begin
                        r_op <= r_op + 1'b1;
                    end
                    if (r_sweep_cnt == 5'd16) begin
                        r_selftest_done <= 1'b1;
                        r_selftest_fail <= r_mis | w_mismatch;
                        r_op            <= '0;
                        r_state         <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_or_arbiter.sv
// Self-checking bench for and_or_arbiter: directed steps plus randomized
// transactions against a behavioural model of grant order and cell function.
module tb_and_or_arbiter;

    localparam int N  = 4;
    localparam int IW = $clog2(N);
`ifdef ANDOR_ARB_SWEEP_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IW-1:0]  rsp_id;
    logic           rsp_y;
    logic           busy;
`ifdef ANDOR_ARB_SWEEP_EN
    logic           selftest_done;
    logic           selftest_fail;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    and_or_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
`ifdef ANDOR_ARB_SWEEP_EN
        ,
        .selftest_done (selftest_done),
        .selftest_fail (selftest_fail)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: result is 1 when both top bits or both bottom bits are set.
    function automatic logic model_y(input logic [3:0] op);
        return ((op >> 2) == 4'd3) || ((op & 4'd3) == 4'd3);
    endfunction

    // Reference: first valid requester at or after ptr, wrapping around.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

`ifdef ANDOR_ARB_SWEEP_EN
    task automatic wait_sweep;
        int n;
        n = 0;
        req_valid = '1;
        #1;
        while (req_ready == '0 && n < 40) begin
            @(negedge clk);
            n++;
            #1;
        end
        check("sweep_cycles", 32'(n), 32'd17);
        check("selftest_done", 32'(selftest_done), 32'd1);
        check("selftest_fail", 32'(selftest_fail), 32'd0);
        req_valid = '0;
    endtask
`endif

    task automatic release_reset;
        rst_n = 1'b1;
        m_ptr = 0;
`ifdef ANDOR_ARB_SWEEP_EN
        wait_sweep();
`endif
    endtask

    // One full transaction, entered and left right after a negedge in IDLE.
    task automatic serve(input logic [N-1:0] v, input logic [4*N-1:0] d, input int hold,
                         input logic keep, output int g);
        logic [3:0] op;
        logic       ey;
        req_valid = v;
        req_data  = d;
        rsp_ready = 1'b0;
        #1;
        g  = model_pick(v, m_ptr);
        op = d[4*g +: 4];
        ey = model_y(op);
        check("grant", 32'(req_ready), 32'(1 << g));
        check("idle_busy", 32'(busy), 32'd0);
        m_ptr = (g + 1) % N;
        @(negedge clk);
        if (!keep) req_valid = '0;
        check("eval_ready", 32'(req_ready), 32'd0);
        check("eval_busy", 32'(busy), 32'd1);
        check("eval_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_y", 32'(rsp_y), 32'(ey));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'(g));
            check("hold_y", 32'(rsp_y), 32'(ey));
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_idle_busy", 32'(busy), 32'd0);
        check("back_idle_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int g;
        int fair_order [6] = '{0, 1, 2, 3, 0, 1};
        longint t_prev;
        logic [N-1:0]   v;
        logic [4*N-1:0] d;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_y", 32'(rsp_y), 32'd0);
        check("rst_busy", 32'(busy), 32'(RST_BUSY));
        check("rst_req_ready", 32'(req_ready), 32'd0);
        release_reset();

        // Fairness: all valid, rsp_ready immediately -> 0,1,2,3,0,1 every 3 cycles
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) check("fair_period", 32'($time - t_prev), 32'd30);
            t_prev = $time;
            serve('1, 16'h37A5, 0, 1'b1, g);
            check("fair_order", 32'(g), 32'(fair_order[i]));
        end
        req_valid = '0;

        // Single request from requester 2 with operand 1100
        serve(4'b0100, 16'h0C00, 0, 1'b0, g);
        check("single_id", 32'(g), 32'd2);

        // Truth values through requester 0
        serve(4'b0001, 16'h000A, 0, 1'b0, g);
        serve(4'b0001, 16'h0003, 0, 1'b0, g);
        serve(4'b0001, 16'h0000, 0, 1'b0, g);

        // Backpressure: five cycles of rsp_ready low in RESP
        serve(4'b1000, 16'hF000, 5, 1'b0, g);

        // Randomized transactions with idle gaps and backpressure
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            req_valid = '0;
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                #1;
                check("gap_ready", 32'(req_ready), 32'd0);
                check("gap_busy", 32'(busy), 32'd0);
            end
            v = N'($urandom_range(1, (1 << N) - 1));
            d = 16'($urandom);
            serve(v, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)), g);
        end
        req_valid = '0;

        // Reset while in EVAL: transaction dropped, pointer back to 0
        req_valid = 4'b0010;
        req_data  = 16'h00F0;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_eval_valid", 32'(rsp_valid), 32'd0);
        check("rst_eval_busy", 32'(busy), 32'(RST_BUSY));
        @(negedge clk);
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        serve('1, 16'h1234, 0, 1'b0, g);
        check("post_rst_first", 32'(g), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
